// File: rtl/data_path_muxs_pkg.sv
// Shared datapath mux selections and fetch-stage types.
// The PC-mux select encoding is what the control unit drives on pc_src.
package data_path_muxs_pkg;

    typedef enum logic [1:0] {
        SEL_LOAD_ADDR      = 2'd0,
        SEL_LOAD_JR_ADDR   = 2'd1,
        SEL_LOAD_NXT_INSTR = 2'd2,
        SEL_LOAD_IMM16     = 2'd3
    } pc_mux_input_selection;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Word-scaled, sign-extended branch displacement taken from instr[15:0].
    function automatic logic signed [31:0] imm16_offset(input logic [31:0] ins);
        return {{14{ins[15]}}, ins[15:0], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: requests a word at pc, holds it
// for decode, then steps pc through the control-selected next-PC mux.
module pc_fetch_unit
    import data_path_muxs_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        advance,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        halted
);

    fetch_state_t          state;
    pc_mux_input_selection sel;
    logic signed [31:0]    branch_off;
    logic [31:0]           branch_target;
    logic [31:0]           jump_target;
    logic [31:0]           next_pc;

    assign npc           = pc + PC_STEP;
    assign imemaddr      = pc;
    assign sel           = pc_mux_input_selection'(pc_src);
    assign branch_off    = imm16_offset(instr);
    assign branch_target = npc + branch_off;
    assign jump_target   = {npc[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = npc;
        case (sel)
            SEL_LOAD_ADDR:      next_pc = jump_target;
            SEL_LOAD_JR_ADDR:   next_pc = jr_addr;
            SEL_LOAD_NXT_INSTR: next_pc = npc;
            SEL_LOAD_IMM16:     next_pc = branch_taken ? branch_target : npc;
            default:            next_pc = npc;
        endcase
    end

    // Status outputs are registered alongside the state so they change only on edges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            instr       <= 32'h0;
            imemREN     <= 1'b1;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        instr       <= imemload;
                        state       <= HOLD;
                        imemREN     <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc      <= next_pc;
                            state   <= FETCH;
                            imemREN <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state       <= FETCH;
                    imemREN     <= 1'b1;
                    instr_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule
